stage_fifo_n: RTL and testbench

Parametrised dual-issue stage FIFO: accepts 0, 1 or 2 in-order entries per cycle and delivers 0, 1 or 2 in-order entries per cycle, with configurable width and depth. It adds an occupancy count, an almost-full flag and sticky protocol-error flags. It sits between pipeline stages, for example fetch→decode or LSU response paths, wherever a 2-deep stage buffer is too shallow.

---
 rtl/stage_fifo_pkg.sv | 28 ++
 rtl/stage_fifo_mem.sv | 41 ++++
 rtl/stage_fifo_n.sv | 105 ++++++++++
 tb/tb_stage_fifo_n.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/stage_fifo_pkg.sv
// Shared definitions for the dual-issue stage FIFO: issue-count encodings
// and pointer arithmetic helpers.
package stage_fifo_pkg;

    typedef enum logic [1:0] {
        N0 = 2'b00,
        N1 = 2'b01,
        N2 = 2'b11
    } dual_cnt_e;

    // Thermometer issue count to integer; the illegal 10 encoding counts as none.
    function automatic int unsigned cnt2(logic [1:0] v);
        case (v)
            N1:      return 1;
            N2:      return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned ptr_add(int unsigned ptr, int unsigned n,
                                            int unsigned depth);
        int unsigned sum;
        sum = ptr + n;
        if (sum >= depth) sum = sum - depth;
        return sum;
    endfunction

endpackage

// File: rtl/stage_fifo_mem.sv
// Depth x Width flop storage with two write ports and two combinational
// read ports; port 0 wins on an address collision.
module stage_fifo_mem
    import stage_fifo_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4,
    parameter int unsigned AW    = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we0_i,
    input  logic [AW-1:0]    waddr0_i,
    input  logic [Width-1:0] wdata0_i,
    input  logic             we1_i,
    input  logic [AW-1:0]    waddr1_i,
    input  logic [Width-1:0] wdata1_i,
    input  logic [AW-1:0]    raddr0_i,
    output logic [Width-1:0] rdata0_o,
    input  logic [AW-1:0]    raddr1_i,
    output logic [Width-1:0] rdata1_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                // Port 0 is evaluated last so it takes priority.
                if (we1_i && waddr1_i == AW'(i)) mem_q[i] <= wdata1_i;
                if (we0_i && waddr0_i == AW'(i)) mem_q[i] <= wdata0_i;
            end
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/stage_fifo_n.sv
// Dual-issue in-order stage FIFO with occupancy count, almost-full flag and
// sticky protocol-error flags.
module stage_fifo_n
    import stage_fifo_pkg::*;
#(
    parameter int unsigned Width         = 32,
    parameter int unsigned Depth         = 4,
    parameter int unsigned AlmostFullThr = Depth - 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       wr_hold_i,
    input  logic [1:0]                 wr_valid_i,
    input  logic [Width-1:0]           wr_data0_i,
    input  logic [Width-1:0]           wr_data1_i,
    output logic [1:0]                 wr_rdy_o,
    input  logic [1:0]                 rd_rdy_i,
    output logic [1:0]                 rd_valid_o,
    output logic [Width-1:0]           rd_data0_o,
    output logic [Width-1:0]           rd_data1_o,
    output logic [$clog2(Depth+1)-1:0] level_o,
    output logic                       almost_full_o,
    output logic [1:0]                 err_o
);

    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned LW = $clog2(Depth + 1);

    logic [PW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr1, wr_ptr1;
    logic [LW-1:0] level_q, level_d;
    logic [1:0]    err_q;
    logic          af_q;
    logic          wr_ill, rd_ill;
    int unsigned   nrd, nwr, room, req;

    assign rd_ptr1 = PW'(ptr_add(32'(rd_ptr_q), 1, Depth));
    assign wr_ptr1 = PW'(ptr_add(32'(wr_ptr_q), 1, Depth));

    always_comb begin
        wr_ill     = (wr_valid_i == 2'b10);
        rd_ill     = (rd_rdy_i == 2'b10);
        rd_valid_o = flush_i ? 2'b00 : {level_q >= LW'(2), level_q >= LW'(1)};
        req        = cnt2(rd_rdy_i);
        nrd        = (req < cnt2(rd_valid_o)) ? req : cnt2(rd_valid_o);
        // Same-cycle reads free room, giving the rd_rdy_i -> wr_rdy_o path.
        room       = Depth - 32'(level_q) + nrd;
        wr_rdy_o   = (flush_i || wr_hold_i) ? 2'b00 : {room >= 2, room >= 1};
        req        = cnt2(wr_valid_i);
        nwr        = (req < cnt2(wr_rdy_o)) ? req : cnt2(wr_rdy_o);
        level_d    = LW'(32'(level_q) + nwr - nrd);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= '0;
            af_q     <= 1'b0;
        end else begin
            rd_ptr_q <= PW'(ptr_add(32'(rd_ptr_q), nrd, Depth));
            wr_ptr_q <= PW'(ptr_add(32'(wr_ptr_q), nwr, Depth));
            level_q  <= level_d;
            err_q    <= err_q | {rd_ill, wr_ill};
            af_q     <= (32'(level_d) >= AlmostFullThr);
        end
    end

    stage_fifo_mem #(
        .Width (Width),
        .Depth (Depth),
        .AW    (PW)
    ) u_mem (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we0_i    (nwr >= 1),
        .waddr0_i (wr_ptr_q),
        .wdata0_i (wr_data0_i),
        .we1_i    (nwr == 2),
        .waddr1_i (wr_ptr1),
        .wdata1_i (wr_data1_i),
        .raddr0_i (rd_ptr_q),
        .rdata0_o (rd_data0_o),
        .raddr1_i (rd_ptr1),
        .rdata1_o (rd_data1_o)
    );

    assign level_o       = level_q;
    assign almost_full_o = af_q;
    assign err_o         = err_q;

`ifdef FORMAL
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (32'(level_q) <= Depth);
            assert (32'(level_q) + nwr - nrd <= Depth);
            assert (nrd <= 32'(level_q));
            // Pointer distance matching level keeps reads in write order.
            assert ((32'(wr_ptr_q) + Depth - 32'(rd_ptr_q)) % Depth == 32'(level_q) % Depth);
        end
    end
`endif

endmodule

// File: tb/tb_stage_fifo_n.sv
// Directed plus randomized bench for stage_fifo_n against a queue-based model.
module tb_stage_fifo_n;

    logic       clk = 1'b0;
    logic       rst, flush, hold;
    logic [1:0] wv, rr;
    logic [7:0] d0, d1;
    logic [1:0] wr_rdy, rd_valid, err;
    logic [7:0] q0, q1;
    logic [2:0] level;
    logic       af;

    int compared = 0;
    int fails    = 0;

    logic [7:0] mq[$];
    logic [1:0] merr;

    always #5 clk = ~clk;

    stage_fifo_n #(
        .Width         (8),
        .Depth         (4),
        .AlmostFullThr (3)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .wr_hold_i     (hold),
        .wr_valid_i    (wv),
        .wr_data0_i    (d0),
        .wr_data1_i    (d1),
        .wr_rdy_o      (wr_rdy),
        .rd_rdy_i      (rr),
        .rd_valid_o    (rd_valid),
        .rd_data0_o    (q0),
        .rd_data1_o    (q1),
        .level_o       (level),
        .almost_full_o (af),
        .err_o         (err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic int cnt(input logic [1:0] v);
        return (v == 2'b01) ? 1 : (v == 2'b11) ? 2 : 0;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One cycle: drive, check combinational and registered outputs, advance model.
    task automatic step(input logic fl, input logic hd, input logic [1:0] w,
                        input logic [7:0] a, input logic [7:0] b, input logic [1:0] r);
        int l, nrd, room, nwr;
        logic [1:0] erv, ewr;
        flush = fl; hold = hd; wv = w; d0 = a; d1 = b; rr = r;
        #1;
        l    = mq.size();
        erv  = fl ? 2'b00 : (l >= 2 ? 2'b11 : l == 1 ? 2'b01 : 2'b00);
        nrd  = imin(cnt(r), l);
        if (fl) nrd = 0;
        room = 4 - l + nrd;
        ewr  = (fl || hd) ? 2'b00 : (room >= 2 ? 2'b11 : room == 1 ? 2'b01 : 2'b00);
        nwr  = imin(cnt(w), cnt(ewr));
        chk("rd_valid", 32'(rd_valid), 32'(erv));
        chk("wr_rdy", 32'(wr_rdy), 32'(ewr));
        chk("level", 32'(level), 32'(l));
        chk("almost_full", 32'(af), 32'(l >= 3));
        chk("err", 32'(err), 32'(merr));
        if (l >= 1) chk("rd_data0", 32'(q0), 32'(mq[0]));
        if (l >= 2) chk("rd_data1", 32'(q1), 32'(mq[1]));
        if (fl) begin
            mq.delete();
            merr = 2'b00;
        end else begin
            for (int i = 0; i < nrd; i++) void'(mq.pop_front());
            if (nwr >= 1) mq.push_back(a);
            if (nwr == 2) mq.push_back(b);
            merr = merr | {r == 2'b10, w == 2'b10};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        merr = 2'b00;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; hold = 1'b0; wv = 2'b00; rr = 2'b00; d0 = '0; d1 = '0;
        merr = 2'b00;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_wr_rdy", 32'(wr_rdy), 32'h3);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_af", 32'(af), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_data0", 32'(q0), 32'h0);

        // Fill, then full with simultaneous read2/write2, then drain across wrap
        step(0, 0, 2'b11, 8'h01, 8'h02, 2'b00);
        step(0, 0, 2'b11, 8'h03, 8'h04, 2'b00);
        chk("full_wr_rdy", 32'(wr_rdy), 32'h0);
        chk("full_data0", 32'(q0), 32'h01);
        step(0, 0, 2'b00, 8'h00, 8'h00, 2'b00);
        step(0, 0, 2'b11, 8'h05, 8'h06, 2'b11);
        chk("fullrw_level", 32'(level), 32'h4);
        chk("wrap_data0", 32'(q0), 32'h03);
        step(0, 0, 2'b00, 8'h00, 8'h00, 2'b11);
        chk("wrap_data1", 32'(q1), 32'h06);
        step(0, 0, 2'b00, 8'h00, 8'h00, 2'b11);

        // Partial accept at level 3, then re-present the rejected entry
        step(0, 0, 2'b11, 8'h01, 8'h02, 2'b00);
        step(0, 0, 2'b01, 8'h03, 8'h00, 2'b00);
        step(0, 0, 2'b11, 8'h0A, 8'h0B, 2'b00);
        step(0, 0, 2'b00, 8'h00, 8'h00, 2'b11);
        step(0, 0, 2'b01, 8'h0B, 8'h00, 2'b01);
        chk("partial_data0", 32'(q0), 32'h0A);
        chk("partial_data1", 32'(q1), 32'h0B);
        step(0, 0, 2'b00, 8'h00, 8'h00, 2'b11);

        // Illegal encodings, sticky until flush
        step(0, 0, 2'b10, 8'h55, 8'h66, 2'b00);
        step(0, 0, 2'b01, 8'h77, 8'h00, 2'b10);
        step(0, 0, 2'b00, 8'h00, 8'h00, 2'b00);
        chk("err_sticky", 32'(err), 32'h3);
        step(1, 0, 2'b00, 8'h00, 8'h00, 2'b00);
        step(0, 0, 2'b00, 8'h00, 8'h00, 2'b00);

        // Flush at level 2 alongside write2
        step(0, 0, 2'b11, 8'h33, 8'h44, 2'b00);
        step(1, 0, 2'b11, 8'h11, 8'h22, 2'b11);
        step(0, 0, 2'b00, 8'h00, 8'h00, 2'b00);

        // Reset mid-stream clears contents and memory
        step(0, 0, 2'b11, 8'h33, 8'h44, 2'b00);
        do_reset();
        chk("midrst_data0", 32'(q0), 32'h0);
        step(0, 0, 2'b00, 8'h00, 8'h00, 2'b00);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0] w, r;
            logic fl, hd;
            w  = ($urandom_range(0, 15) == 0) ? 2'b10 : ($urandom_range(0, 2) == 0) ? 2'b00 :
                 ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
            r  = ($urandom_range(0, 15) == 0) ? 2'b10 : ($urandom_range(0, 2) == 0) ? 2'b00 :
                 ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
            fl = ($urandom_range(0, 40) == 0);
            hd = ($urandom_range(0, 8) == 0);
            step(fl, hd, w, 8'($urandom), 8'($urandom), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end

endmodule
